demux_1x2_nbit: RTL and testbench
=================================

# demux_1x2_nbit

Stream demultiplexer, the receive-side counterpart of the N-bit 2x1 mux: one N-bit valid/ready input stream is routed to one of two N-bit output streams by a select bit. Each output has a 2-entry elastic buffer, so routing is registered, full-throughput, and free of combinational paths from output `ready` to input `ready`. It splits a shared datapath back into two consumers, e.g. after a time-shared mux link.

## Interface
- `N`, 3, data width in bits (N ≥ 1)
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: asynchronous assert, active-low reset
- `in_data` input N: input beat data
- `in_last` input 1: marks the final beat of a packet
- `in_valid` input 1: input beat valid
- `in_ready` output 1: block accepts the beat this cycle
- `s` input 1: destination select (0 → out0, 1 → out1)
- `o0_data` output N, `o0_last` output 1, `o0_valid` output 1, `o0_ready` input 1: output stream 0
- `o1_data` output N, `o1_last` output 1, `o1_valid` output 1, `o1_ready` input 1: output stream 1

## Operation
- Effective select `esel` is `s` (or the locked select, see Configuration).
- Input transfer: `in_valid && in_ready` at a rising edge. The beat `{in_data, in_last}` is pushed into buffer `esel`.
- `in_ready = !full[esel]`. `full` means count == 2. This is a function of registered counts and `esel` only, never of `oX_ready`.
- Output transfer: `oX_valid && oX_ready` pops the buffer head. `oX_valid = (count_X != 0)`. `oX_data`/`oX_last` are the head entry and must stay stable while `oX_valid && !oX_ready`.
- Each buffer is a FIFO: order is preserved per output. There is no ordering relation between out0 and out1.
- Simultaneous push and pop on the same buffer: count is unchanged, and the head advances while the new beat is stored. At count 2 a push is blocked even if a pop occurs in the same cycle.
- Beats routed to one output never stall the other output's drain.
- `in_valid` low: no state change. `in_data` and `s` are don't-care.

## Timing
- Latency: a beat accepted at edge k is visible on `oX_valid`/`oX_data` after edge k. It can be consumed at edge k+1.
- Throughput: 1 beat/cycle per output when `oX_ready` is held high. Count stays at 1 or lower.
- Reset (`rst_n` low, asynchronous): both counts = 0, pointers = 0, lock state = IDLE.
  - `o0_valid = o1_valid = 0`.
  - `in_ready = 1` (derived from empty buffers).
  - `oX_data`/`oX_last` = 0.
- Reset mid-operation: buffered beats are discarded, and a held lock is released. No partial beat appears after deassertion.
- Reset is released synchronously by the surrounding reset synchronizer. The block makes no other assumption.

## Configuration
- Macro: `DEMUX_1X2_PKT_LOCK_EN`.
- Defined: packet lock. FSM with states IDLE and LOCK, plus register `lsel`.
  - IDLE: `esel = s`. An accepted beat with `in_last = 0` sets `lsel = s` and moves to LOCK. An accepted beat with `in_last = 1` stays in IDLE (single-beat packet).
  - LOCK: `esel = lsel`, and `s` is ignored. An accepted beat with `in_last = 1` returns to IDLE. Packets are never split across outputs.
- Undefined: no FSM. `esel = s` on every beat, and `in_last` is passed through unchanged.

## Structure
- Package `demux_1x2_pkg`:
  - lock-state enum `{IDLE, LOCK}`
  - constant `BUF_DEPTH = 2`
  - count width `CNT_W = 2`
- Sub-module `stream_buf2_nbit` (parameter N): 2-entry FIFO with push/pop, `full`, `valid`, head data/last. It is instantiated twice. The top holds the select/lock logic and the `in_ready` mux.

## Test plan
- Reset then idle:
  - `o0_valid = o1_valid = 0` and `in_ready = 1`.
  - Asserting `rst_n` low mid-cycle clears `valid` immediately (async).
- Stream to both outputs with `oX_ready = 1`: `s` = 0,1,0,1 with data 3'h1,2,3,4 → o0 sees 1,3 and o1 sees 2,4, each one cycle after acceptance, with no stall.
- Backpressure:
  - `o0_ready = 0`, push 3'h5, 3'h6 to out0 → `in_ready = 0` on the third out0 beat.
  - Beats to out1 (`s = 1`, 3'h7) are still accepted and delivered.
  - Releasing `o0_ready` drains 5 then 6 in order.
- Full with simultaneous pop: out0 count 2, `o0_ready = 1`, `in_valid = 1` with `s = 0` → the push is blocked that cycle and accepted on the next cycle.
- With `DEMUX_1X2_PKT_LOCK_EN`: a 3-beat packet (in_last 0,0,1, data 1,2,3) starts with `s = 1` and `s` toggles mid-packet → all three beats go to out1. The next packet with `s = 0` goes to out0.
- Reset mid-packet: lock held and out1 buffer full, then `rst_n` pulsed low → after release the state is IDLE, buffers are empty, and the next beat follows `s`.

Source files
------------

// File: rtl/demux_1x2_pkg.sv
// Shared types and constants for the 1-to-2 stream demultiplexer.
// The packet-lock enum is used only when DEMUX_1X2_PKT_LOCK_EN is defined.
package demux_1x2_pkg;

  // Packet-lock FSM states
  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } lock_state_t;

  // Entries per output elastic buffer
  localparam int unsigned BUF_DEPTH = 2;

  // Width of the occupancy counter (holds 0..BUF_DEPTH)
  localparam int unsigned CNT_W = 2;

endpackage

// File: rtl/stream_buf2_nbit.sv
// Two-entry FIFO holding {data, last}. The head is driven straight from storage,
// so it stays stable until it is popped.
module stream_buf2_nbit
  import demux_1x2_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [N-1:0] push_data,
  input  logic         push_last,
  input  logic         pop,
  output logic         full,
  output logic         valid,
  output logic [N-1:0] head_data,
  output logic         head_last
);

  logic [N:0]       mem [BUF_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full      = (count == CNT_W'(BUF_DEPTH));
  assign valid     = (count != '0);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && valid;
  assign head_data = mem[rd_ptr][N:1];
  assign head_last = mem[rd_ptr][0];

  // Storage, pointers and occupancy; push at count 2 is refused even with a pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= {push_data, push_last};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux_1x2_nbit.sv
// Routes one valid/ready stream to one of two buffered output streams.
// Optional packet lock (keeps a whole packet on one output): DEMUX_1X2_PKT_LOCK_EN.
module demux_1x2_nbit
  import demux_1x2_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in_data,
  input  logic         in_last,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         s,
  output logic [N-1:0] o0_data,
  output logic         o0_last,
  output logic         o0_valid,
  input  logic         o0_ready,
  output logic [N-1:0] o1_data,
  output logic         o1_last,
  output logic         o1_valid,
  input  logic         o1_ready
);

  logic esel;
  logic accept;
  logic full0;
  logic full1;

  // in_ready depends only on registered occupancy and the effective select
  assign in_ready = esel ? !full1 : !full0;
  assign accept   = in_valid && in_ready;

`ifdef DEMUX_1X2_PKT_LOCK_EN
  lock_state_t state;
  lock_state_t state_nxt;
  logic        lsel;
  logic        lsel_nxt;

  // Lock state and latched select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lsel  <= 1'b0;
    end else begin
      state <= state_nxt;
      lsel  <= lsel_nxt;
    end
  end

  // Lock on the first beat of a multi-beat packet, release on its last beat
  always_comb begin
    state_nxt = state;
    lsel_nxt  = lsel;
    case (state)
      IDLE: begin
        if (accept && !in_last) begin
          state_nxt = LOCK;
          lsel_nxt  = s;
        end
      end
      LOCK: begin
        if (accept && in_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign esel = (state == LOCK) ? lsel : s;
`else
  assign esel = s;
`endif

  stream_buf2_nbit #(.N(N)) u_buf0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept && !esel),
    .push_data (in_data),
    .push_last (in_last),
    .pop       (o0_ready),
    .full      (full0),
    .valid     (o0_valid),
    .head_data (o0_data),
    .head_last (o0_last)
  );

  stream_buf2_nbit #(.N(N)) u_buf1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept && esel),
    .push_data (in_data),
    .push_last (in_last),
    .pop       (o1_ready),
    .full      (full1),
    .valid     (o1_valid),
    .head_data (o1_data),
    .head_last (o1_last)
  );

endmodule

// File: tb/tb_demux_1x2_nbit.sv
// Scoreboard bench for demux_1x2_nbit: the driver queues the expected beat per
// destination, and a monitor compares each output head against its queue.
module tb_demux_1x2_nbit;

  localparam int unsigned N = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] in_data;
  logic         in_last;
  logic         in_valid;
  logic         in_ready;
  logic         s;
  logic [N-1:0] o0_data;
  logic         o0_last;
  logic         o0_valid;
  logic         o0_ready;
  logic [N-1:0] o1_data;
  logic         o1_last;
  logic         o1_valid;
  logic         o1_ready;

  int errors = 0;
  int checks = 0;

  logic [N:0] q0[$];
  logic [N:0] q1[$];

  demux_1x2_nbit #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .s        (s),
    .o0_data  (o0_data),
    .o0_last  (o0_last),
    .o0_valid (o0_valid),
    .o0_ready (o0_ready),
    .o1_data  (o1_data),
    .o1_last  (o1_last),
    .o1_valid (o1_valid),
    .o1_ready (o1_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each valid head with the queue front, pop on handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (o0_valid) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL out0 unexpected beat: got %0d/%0d expected none", o0_data, o0_last);
        end else begin
          if ({o0_data, o0_last} !== q0[0]) begin
            errors++;
            $display("FAIL out0 beat: got %0d/%0d expected %0d/%0d", o0_data, o0_last,
                     q0[0][N:1], q0[0][0]);
          end
          if (o0_ready) void'(q0.pop_front());
        end
      end
      if (o1_valid) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL out1 unexpected beat: got %0d/%0d expected none", o1_data, o1_last);
        end else begin
          if ({o1_data, o1_last} !== q1[0]) begin
            errors++;
            $display("FAIL out1 beat: got %0d/%0d expected %0d/%0d", o1_data, o1_last,
                     q1[0][N:1], q1[0][0]);
          end
          if (o1_ready) void'(q1.pop_front());
        end
      end
    end
  end

  // Present one beat (called at posedge+1), wait for acceptance, queue it for dest
  task automatic send(input logic [N-1:0] d, input logic l, input logic sel,
                      input logic dest, output int waited);
    int n;
    in_data  = d;
    in_last  = l;
    s        = sel;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send timeout", 0, 1);
    if (dest) q1.push_back({d, l});
    else      q0.push_back({d, l});
    waited = n;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    #12;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [N-1:0] vd [4] = '{3'h1, 3'h2, 3'h3, 3'h4};
  logic         vs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  // Packet vectors: data, last, s, expected destination
  logic [N-1:0] pd [4] = '{3'h1, 3'h2, 3'h3, 3'h4};
  logic         pl [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic         ps [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
`ifdef DEMUX_1X2_PKT_LOCK_EN
  logic         pe [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
`else
  logic         pe [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
`endif

  initial begin
    int w;
    rst_n    = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    in_valid = 1'b0;
    s        = 1'b0;
    o0_ready = 1'b1;
    o1_ready = 1'b1;
    #12;
    chk("reset o0_valid", int'(o0_valid), 0);
    chk("reset o1_valid", int'(o1_valid), 0);
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset o0_data", int'(o0_data), 0);
    chk("reset o1_last", int'(o1_last), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    chk("idle o0_valid", int'(o0_valid), 0);

    // Alternating stream, both outputs ready: no stall, visible right after accept
    for (int i = 0; i < 4; i++) begin
      send(vd[i], 1'b1, vs[i], vs[i], w);
      chk("stream no stall", w, 0);
      chk("stream latency", int'(vs[i] ? o1_valid : o0_valid), 1);
    end
    idle(3);
    chk("stream q0 drained", q0.size(), 0);
    chk("stream q1 drained", q1.size(), 0);

    // Backpressure on out0; out1 keeps flowing
    o0_ready = 1'b0;
    send(3'h5, 1'b1, 1'b0, 1'b0, w);
    send(3'h6, 1'b1, 1'b0, 1'b0, w);
    s = 1'b0;
    in_data = 3'h2;
    in_valid = 1'b1;
    @(negedge clk);
    chk("bp in_ready s0 full", int'(in_ready), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    send(3'h7, 1'b1, 1'b1, 1'b1, w);
    chk("bp out1 no stall", w, 0);
    idle(3);
    chk("bp out1 delivered", q1.size(), 0);
    chk("bp out0 held", q0.size(), 2);
    chk("bp o0_valid held", int'(o0_valid), 1);
    o0_ready = 1'b1;
    idle(3);
    chk("bp out0 drained", q0.size(), 0);

    // Full buffer with simultaneous pop: push refused that cycle, taken the next
    o0_ready = 1'b0;
    send(3'h1, 1'b0, 1'b0, 1'b0, w);
    send(3'h2, 1'b1, 1'b0, 1'b0, w);
    o0_ready = 1'b1;
    in_data  = 3'h3;
    in_last  = 1'b1;
    s        = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    chk("full+pop blocked", int'(in_ready), 0);
    @(negedge clk);
    chk("full+pop next accepted", int'(in_ready), 1);
    q0.push_back({3'h3, 1'b1});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    idle(4);
    chk("full+pop drained", q0.size(), 0);

    // Async reset clears valid without a clock edge
    o1_ready = 1'b0;
    send(3'h4, 1'b1, 1'b1, 1'b1, w);
    #2;
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    chk("async rst o1_valid", int'(o1_valid), 0);
    chk("async rst o1_data", int'(o1_data), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    o1_ready = 1'b1;

    // Packet routing with s toggling mid-packet
    for (int i = 0; i < 4; i++) begin
      send(pd[i], pl[i], ps[i], pe[i], w);
    end
    idle(4);
    chk("pkt q0 drained", q0.size(), 0);
    chk("pkt q1 drained", q1.size(), 0);

    // Reset mid-packet with out1 full, then the next beat follows s
    o1_ready = 1'b0;
    send(3'h5, 1'b0, 1'b1, 1'b1, w);
    send(3'h6, 1'b0, 1'b1, 1'b1, w);
    chk("midpkt out1 full", int'(in_ready), 0);
    do_reset();
    o1_ready = 1'b1;
    chk("midpkt rst o1_valid", int'(o1_valid), 0);
    chk("midpkt rst in_ready", int'(in_ready), 1);
    send(3'h7, 1'b1, 1'b0, 1'b0, w);
    chk("midpkt follows s", int'(o0_valid), 1);
    chk("midpkt o1 empty", int'(o1_valid), 0);
    idle(4);
    chk("final q0 drained", q0.size(), 0);
    chk("final q1 drained", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
